// File: rtl/audio_playback_ctrl_pkg.sv
// Shared types and constants for the audio playback controller.
// Holds the FSM state encoding, default geometry and the half-word select helper.
package audio_pkg;

  localparam int ADDR_W = 23;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W = 2 * SAMPLE_W;
  localparam int SPEED_W = 16;
  localparam logic [SPEED_W-1:0] SPEED_DEFAULT = 16'd1136;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    HALF0,
    HALF1
  } play_state_t;

  // lo=1 picks the low sample of the word, lo=0 the high sample
  function automatic logic [SAMPLE_W-1:0] pick_half(input logic [WORD_W-1:0] word,
                                                    input logic lo);
    return lo ? word[SAMPLE_W-1:0] : word[WORD_W-1:SAMPLE_W];
  endfunction

endpackage

// File: rtl/audio_playback_ctrl_if.sv
// Flash read port: read/waitrequest/readdatavalid handshake on word addresses.
// The controller is the master; the flash (or its model) is the slave.
interface audio_playback_ctrl_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) ();

  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest;
  logic              flash_readdatavalid;
  logic [DATA_W-1:0] flash_readdata;

  modport master (
    output flash_read,
    output flash_address,
    input  flash_waitrequest,
    input  flash_readdatavalid,
    input  flash_readdata
  );

  modport slave (
    input  flash_read,
    input  flash_address,
    output flash_waitrequest,
    output flash_readdatavalid,
    output flash_readdata
  );

endinterface

// File: rtl/audio_playback_ctrl_sample_tick_gen.sv
// Sample-rate divider: one tick every max(speed_control,1) cycles while enabled.
// The >= compare lets a shortened period take effect at once instead of wrapping.
module sample_tick_gen
  import audio_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed_control,
  output logic               tick
);

  logic [SPEED_W-1:0] r_count;
  logic [SPEED_W-1:0] w_limit;
  logic               w_expire;

  assign w_limit  = (speed_control == '0) ? '0 : speed_control - 1'b1;
  assign w_expire = (r_count >= w_limit);
  assign tick     = enable && w_expire;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (!enable || w_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/audio_playback_ctrl.sv
// Audio playback sequencer: fetches 32-bit flash words and plays them out as
// two 16-bit samples on each divider tick, with pause, direction and restart.
module audio_playback_ctrl #(
  parameter int ADDR_W = audio_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = audio_pkg::LAST_ADDR,
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         speed_control,
  input  logic                play,
  input  logic                forward,
  input  logic                restart,
  audio_playback_ctrl_if.master flash,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                underrun
);

  import audio_pkg::*;

  play_state_t         r_state;
  play_state_t         w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [2*SAMPLE_W-1:0] r_word;
  logic                r_dir;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_valid;
  logic                r_underrun;
  logic                r_restart_pending;

  logic                w_tick;
  logic                w_emit;
  logic [SAMPLE_W-1:0] w_emit_data;
  logic                w_underrun;
  logic                w_latch;
  logic                w_enter_req;
  logic                w_restart_load;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic fwd);
    if (fwd) return (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    return (addr == '0) ? LAST_ADDR : addr - 1'b1;
  endfunction

  sample_tick_gen u_tick (
    .clock         (clock),
    .reset         (reset),
    .enable        (play),
    .speed_control (speed_control),
    .tick          (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_emit      = 1'b0;
    w_emit_data = r_sample;
    w_underrun  = 1'b0;
    w_latch     = 1'b0;
    w_enter_req = 1'b0;
    case (r_state)
      IDLE: begin
        if (play) begin
          w_state_nxt = REQ;
          w_enter_req = 1'b1;
        end
      end
      REQ: begin
        w_underrun = w_tick;
        if (!flash.flash_waitrequest) w_state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        w_underrun = w_tick;
        if (flash.flash_readdatavalid) begin
          w_latch     = 1'b1;
          w_state_nxt = HALF0;
        end
      end
      HALF0: begin
        if (w_tick) begin
          w_emit      = 1'b1;
          w_emit_data = pick_half(r_word, r_dir);
          w_state_nxt = HALF1;
        end
        if (restart) begin
          w_state_nxt = REQ;
          w_enter_req = 1'b1;
        end
      end
      HALF1: begin
        if (w_tick) begin
          w_emit      = 1'b1;
          w_emit_data = pick_half(r_word, !r_dir);
          w_addr_nxt  = step_addr(r_addr, r_dir);
          w_state_nxt = REQ;
          w_enter_req = 1'b1;
        end
        if (restart) begin
          w_state_nxt = REQ;
          w_enter_req = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // a pending or same-cycle restart overrides any address step
    w_restart_load = w_enter_req && (restart || r_restart_pending);
    if (w_restart_load) w_addr_nxt = forward ? '0 : LAST_ADDR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr            <= '0;
      r_word            <= '0;
      r_dir             <= 1'b1;
      r_sample          <= '0;
      r_valid           <= 1'b0;
      r_underrun        <= 1'b0;
      r_restart_pending <= 1'b0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_valid    <= w_emit;
      r_underrun <= w_underrun;
      if (w_latch) begin
        r_word <= flash.flash_readdata;
        r_dir  <= forward;
      end
      if (w_emit) r_sample <= w_emit_data;
      if (w_restart_load) begin
        r_restart_pending <= 1'b0;
      end else if (restart) begin
        r_restart_pending <= 1'b1;
      end
    end
  end

  assign flash.flash_read    = (r_state == REQ);
  assign flash.flash_address = r_addr;
  assign sample_out          = r_sample;
  assign sample_valid        = r_valid;
  assign underrun            = r_underrun;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Directed bench for audio_playback_ctrl with a one-cycle-latency flash model.
module tb_audio_playback_ctrl;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clock;
  logic        reset;
  logic [15:0] speed_control;
  logic        play;
  logic        forward;
  logic        restart;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  audio_playback_ctrl_if #(.ADDR_W(23), .DATA_W(32)) u_flash ();

  audio_playback_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .speed_control (speed_control),
    .play          (play),
    .forward       (forward),
    .restart       (restart),
    .flash         (u_flash),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .underrun      (underrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == 23'd0) return 32'hBBBB_AAAA;
    if (a == LAST) return 32'h2222_1111;
    return {a[15:0] + 16'h1000, a[15:0]};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      u_flash.flash_readdatavalid <= 1'b0;
    end else begin
      u_flash.flash_readdatavalid <= 1'b0;
      if (u_flash.flash_read && !u_flash.flash_waitrequest) begin
        u_flash.flash_readdatavalid <= 1'b1;
        u_flash.flash_readdata      <= mem_word(u_flash.flash_address);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    play = 1'b0;
    restart = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_valid(output logic [15:0] d, output int n);
    d = 'x;
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clock);
      if (sample_valid === 1'b1) begin
        d = sample_out;
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_read();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (u_flash.flash_read === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    play = 1'b0;
    restart = 1'b0;
    forward = 1'b1;
    speed_control = 16'd4;
    u_flash.flash_waitrequest = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (u_flash.flash_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", u_flash.flash_read); end
    checks++; if (u_flash.flash_address !== 23'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", u_flash.flash_address); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL reset_sample got %h exp 0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun); end
  endtask

  task automatic test_forward();
    logic [15:0] d1, d2;
    int n1, n2;
    speed_control = 16'd4;
    forward = 1'b1;
    do_reset();
    play = 1'b1;
    wait_valid(d1, n1);
    wait_valid(d2, n2);
    checks++; if (n1 !== 4) begin errors++; $display("FAIL fwd_latency got %0d exp 4", n1); end
    checks++; if (d1 !== 16'hAAAA) begin errors++; $display("FAIL fwd_s0 got %h exp aaaa", d1); end
    checks++; if (d2 !== 16'hBBBB) begin errors++; $display("FAIL fwd_s1 got %h exp bbbb", d2); end
    checks++; if (n2 !== 4) begin errors++; $display("FAIL fwd_spacing got %0d exp 4", n2); end
    checks++; if (u_flash.flash_address !== 23'd1) begin errors++; $display("FAIL fwd_next_addr got %h exp 1", u_flash.flash_address); end
    checks++; if (u_flash.flash_read !== 1'b1) begin errors++; $display("FAIL fwd_next_read got %b exp 1", u_flash.flash_read); end
  endtask

  task automatic test_backward_restart();
    logic [15:0] d1, d2;
    int n1, n2;
    speed_control = 16'd4;
    forward = 1'b0;
    do_reset();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    play = 1'b1;
    wait_read();
    checks++; if (u_flash.flash_address !== LAST) begin errors++; $display("FAIL bwd_start_addr got %h exp 7ffff", u_flash.flash_address); end
    wait_valid(d1, n1);
    wait_valid(d2, n2);
    checks++; if (d1 !== 16'h2222) begin errors++; $display("FAIL bwd_s0 got %h exp 2222", d1); end
    checks++; if (d2 !== 16'h1111) begin errors++; $display("FAIL bwd_s1 got %h exp 1111", d2); end
    checks++; if (u_flash.flash_address !== 23'h7FFFE) begin errors++; $display("FAIL bwd_next_addr got %h exp 7fffe", u_flash.flash_address); end
  endtask

  task automatic test_wrap();
    logic [15:0] d1, d2;
    int n1, n2;
    speed_control = 16'd4;
    forward = 1'b0;
    do_reset();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    play = 1'b1;
    wait_read();
    forward = 1'b1;
    wait_valid(d1, n1);
    wait_valid(d2, n2);
    checks++; if (d1 !== 16'h1111) begin errors++; $display("FAIL wrapf_s0 got %h exp 1111", d1); end
    checks++; if (d2 !== 16'h2222) begin errors++; $display("FAIL wrapf_s1 got %h exp 2222", d2); end
    checks++; if (u_flash.flash_address !== 23'd0) begin errors++; $display("FAIL wrapf_addr got %h exp 0", u_flash.flash_address); end
    forward = 1'b0;
    do_reset();
    play = 1'b1;
    wait_valid(d1, n1);
    wait_valid(d2, n2);
    checks++; if (d1 !== 16'hBBBB) begin errors++; $display("FAIL wrapb_s0 got %h exp bbbb", d1); end
    checks++; if (d2 !== 16'hAAAA) begin errors++; $display("FAIL wrapb_s1 got %h exp aaaa", d2); end
    checks++; if (u_flash.flash_address !== LAST) begin errors++; $display("FAIL wrapb_addr got %h exp 7ffff", u_flash.flash_address); end
  endtask

  task automatic test_waitrequest();
    logic [15:0] d;
    int n, n_under, n_bad, n_val;
    speed_control = 16'd2;
    forward = 1'b1;
    u_flash.flash_waitrequest = 1'b1;
    do_reset();
    play = 1'b1;
    wait_read();
    n_under = 0;
    n_bad = 0;
    n_val = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      if (underrun === 1'b1) n_under++;
      if (u_flash.flash_read !== 1'b1 || u_flash.flash_address !== 23'd0) n_bad++;
      if (sample_valid !== 1'b0) n_val++;
    end
    checks++; if (n_under !== 5) begin errors++; $display("FAIL wr_underruns got %0d exp 5", n_under); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL wr_req_stable got %0d bad cycles exp 0", n_bad); end
    checks++; if (n_val !== 0) begin errors++; $display("FAIL wr_no_valid got %0d exp 0", n_val); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL wr_sample_held got %h exp 0", sample_out); end
    u_flash.flash_waitrequest = 1'b0;
    wait_valid(d, n);
    checks++; if (d !== 16'hAAAA) begin errors++; $display("FAIL wr_first got %h exp aaaa", d); end
  endtask

  task automatic test_pause();
    logic [15:0] d;
    int n, n_val, n_chg, n_rd;
    speed_control = 16'd4;
    forward = 1'b1;
    do_reset();
    play = 1'b1;
    wait_valid(d, n);
    play = 1'b0;
    n_val = 0;
    n_chg = 0;
    n_rd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (sample_valid !== 1'b0) n_val++;
      if (sample_out !== 16'hAAAA) n_chg++;
      if (u_flash.flash_read !== 1'b0) n_rd++;
    end
    checks++; if (n_val !== 0) begin errors++; $display("FAIL pause_valid got %0d exp 0", n_val); end
    checks++; if (n_chg !== 0) begin errors++; $display("FAIL pause_hold got %0d changes exp 0", n_chg); end
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL pause_read got %0d exp 0", n_rd); end
    play = 1'b1;
    wait_valid(d, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL pause_resume_delay got %0d exp 4", n); end
    checks++; if (d !== 16'hBBBB) begin errors++; $display("FAIL pause_resume_data got %h exp bbbb", d); end
  endtask

  task automatic test_speed_change();
    logic [15:0] d;
    int n, n_val;
    speed_control = 16'd1136;
    forward = 1'b1;
    do_reset();
    play = 1'b1;
    n_val = 0;
    repeat (500) begin
      @(negedge clock);
      if (sample_valid !== 1'b0) n_val++;
    end
    checks++; if (n_val !== 0) begin errors++; $display("FAIL spd_slow_quiet got %0d exp 0", n_val); end
    speed_control = 16'd10;
    @(negedge clock);
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL spd_immediate got %b exp 1", sample_valid); end
    checks++; if (sample_out !== 16'hAAAA) begin errors++; $display("FAIL spd_immediate_data got %h exp aaaa", sample_out); end
    wait_valid(d, n);
    checks++; if (n !== 10 || d !== 16'hBBBB) begin errors++; $display("FAIL spd_period1 got %0d/%h exp 10/bbbb", n, d); end
    wait_valid(d, n);
    checks++; if (n !== 10 || d !== 16'h0001) begin errors++; $display("FAIL spd_period2 got %0d/%h exp 10/0001", n, d); end
    speed_control = 16'd0;
    @(negedge clock);
    checks++; if (sample_valid !== 1'b1 || sample_out !== 16'h1001) begin errors++; $display("FAIL spd_zero_tick got %b/%h exp 1/1001", sample_valid, sample_out); end
    @(negedge clock);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL spd_zero_underrun got %b exp 1", underrun); end
  endtask

  task automatic test_restart_half();
    logic [15:0] d;
    int n;
    speed_control = 16'd20;
    forward = 1'b1;
    do_reset();
    play = 1'b1;
    wait_valid(d, n);
    checks++; if (n !== 20 || d !== 16'hAAAA) begin errors++; $display("FAIL rh_first got %0d/%h exp 20/aaaa", n, d); end
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    checks++; if (u_flash.flash_read !== 1'b1 || u_flash.flash_address !== 23'd0) begin errors++; $display("FAIL rh_jump got %b/%h exp 1/0", u_flash.flash_read, u_flash.flash_address); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rh_discard got %b exp 0", sample_valid); end
    wait_valid(d, n);
    checks++; if (n !== 19 || d !== 16'hAAAA) begin errors++; $display("FAIL rh_replay got %0d/%h exp 19/aaaa", n, d); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backward_restart();
    test_wrap();
    test_waitrequest();
    test_pause();
    test_speed_change();
    test_restart_half();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_playback_ctrl.md
Name: audio_playback_ctrl

Overview:
- Sequences audio playback from the 32-bit flash into the audio output path.
- Converts the 16-bit `speed_control` divider value from the speed-control logic into a sample-rate tick.
- Fetches flash words through a read/waitrequest/readdatavalid handshake and emits one 16-bit sample per tick.
- Supports play/pause, forward/backward direction, restart and address wrap-around.

Parameters:
- ADDR_W, 23, width of the flash word address.
- LAST_ADDR, 23'h7FFFF, last word address of the audio region; playback wraps at this address.
- SAMPLE_W, 16, width of one audio sample (two samples per 32-bit word).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- speed_control  in  16  clock cycles per sample tick; 0 is treated as 1
- play  in  1  1 = run, 0 = pause
- forward  in  1  1 = ascending addresses, 0 = descending
- restart  in  1  single-cycle pulse: jump to start of the track for the current direction
- flash_waitrequest  in  1  slave stall
- flash_readdatavalid  in  1  read data strobe
- flash_readdata  in  32  read data word
- flash_read  out  1  read request
- flash_address  out  ADDR_W  word address
- sample_out  out  SAMPLE_W  current audio sample, held between ticks
- sample_valid  out  1  one-cycle pulse when sample_out updates
- underrun  out  1  one-cycle pulse when a tick arrives with no data ready

Behaviour:
- Reset values:
  - state IDLE; flash_read 0; flash_address 0
  - sample_out 0; sample_valid 0; underrun 0
  - divider count 0; restart_pending 0
- Divider:
  - The count increments every cycle while play=1 and clears while play=0.
  - When count >= max(speed_control,1)-1, a tick fires and the count clears.
  - Using >= means a reduced speed_control takes effect immediately and the count never stalls.
- FSM states: IDLE, REQ, WAIT_DATA, HALF0, HALF1.
- IDLE:
  - Go to REQ when play=1.
- REQ:
  - flash_read=1 with a stable flash_address.
  - Go to WAIT_DATA in the first cycle where flash_waitrequest=0; flash_read drops in that same transition.
- WAIT_DATA:
  - Latch flash_readdata on flash_readdatavalid, then go to HALF0.
  - Direction is sampled at this point and held for both halves of the word.
- HALF0:
  - On tick, sample_out = word[15:0] if forward, else word[31:16].
  - Pulse sample_valid, then go to HALF1.
- HALF1:
  - On tick, output the other half and pulse sample_valid.
  - Advance the address: +1 if forward, -1 if backward.
  - Forward wraps LAST_ADDR -> 0; backward wraps 0 -> LAST_ADDR.
  - Go to REQ.
- Pause (play=0):
  - No ticks are generated, so HALF0/HALF1 hold.
  - An in-flight REQ or WAIT_DATA still completes; the controller never abandons a flash transaction.
  - sample_out holds its last value.
- Underrun:
  - A tick occurring in REQ or WAIT_DATA is dropped and underrun pulses for 1 cycle.
  - sample_out is unchanged.
- Restart:
  - A restart pulse sets restart_pending.
  - On the next entry to REQ (including the REQ entered from HALF1), the address is loaded with 0 (forward) or LAST_ADDR (backward), replacing the increment, and restart_pending clears.
  - If the pulse arrives in HALF0 or HALF1, the FSM jumps straight to REQ at the next cycle and the remaining half-sample is discarded.
  - restart in IDLE applies on the first fetch.
- Simultaneous events:
  - restart together with a HALF1 tick: the sample is still output, and the restart address wins over the increment.
  - reset overrides everything, including a pending handshake.
- Direction change mid-word applies at the next WAIT_DATA latch.
- Latency from play rising in IDLE to the first sample_valid:
  - 1 (REQ entry) + waitrequest cycles + read latency + ticks to the first divider expiry.

Decomposition:
- Shared package `audio_pkg`:
  - state enum `play_state_t` {IDLE, REQ, WAIT_DATA, HALF0, HALF1}
  - ADDR_W, LAST_ADDR, SAMPLE_W constants
  - SPEED_DEFAULT = 16'd1136
- One sub-module, `sample_tick_gen`:
  - the divider.
  - inputs: clock, reset, enable, speed_control; output: tick.
- FSM, address and sample muxing stay in the top module.

Test Plan:
- reset, play=1, forward=1, speed_control=4, zero-wait flash with 1-cycle readdatavalid, word 0 = 32'hBBBB_AAAA -> sample_valid pulses 4 cycles apart with sample_out 16'hAAAA then 16'hBBBB; next flash_address=1.
- forward=0, restart pulse, word LAST_ADDR = 32'h2222_1111 -> flash_address=23'h7FFFF; sample_out 16'h2222 then 16'h1111; next address 23'h7FFFE.
- Wrap: start forward at LAST_ADDR -> after two ticks the next REQ carries flash_address=0.
- flash_waitrequest held high 10 cycles with speed_control=2 -> flash_read stays 1 with a stable address; underrun pulses on each dropped tick; no sample_valid until data returns.
- play=0 in HALF1 for 50 cycles -> no sample_valid, sample_out holds, flash_read stays 0; play=1 resumes with the next half after speed_control cycles.
- speed_control changed from 1136 to 10 while count=500 -> tick on the next cycle, then every 10 cycles; speed_control=0 -> tick every cycle.
